vram_pixel_streamer: RTL and testbench
======================================

Name: vram_pixel_streamer

Overview:
Read-side counterpart to the VRAM draw/clear FSM. On a frame request, it walks the dual-port block RAM read port in raster order and turns the 1-cycle-latency read data into a valid/ready pixel stream. The stream feeds the ili9341 SPI pixel sender and carries first/last framing. It sustains 1 pixel/clk under continuous ready, absorbs arbitrary backpressure without losing or duplicating pixels, and never writes VRAM.

Parameters:
DISPLAY_WIDTH, 240, pixels per row
DISPLAY_HEIGHT, 320, rows per frame
VRAM_W, 16, pixel word width (RGB565, ILI9341_color_t)
AUTO_RESTART, 0, when 1 a new frame starts immediately after frame_done with no start pulse
(localparam) VRAM_L = DISPLAY_WIDTH*DISPLAY_HEIGHT; AW = $clog2(VRAM_L)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ena  in  1  when low, no new VRAM reads issue; in-flight read and buffered pixels still drain
start  in  1  1-cycle pulse, begins a frame from IDLE; ignored otherwise
vram_rd_addr  out  AW  block RAM read address
vram_rd_data  in  VRAM_W  block RAM read data, valid 1 clk after address
pixel_data  out  VRAM_W  streamed pixel
pixel_valid  out  1  pixel_data/first/last are valid
pixel_ready  in  1  sink accepts; transfer = valid & ready
pixel_first  out  1  qualifies pixel at address 0
pixel_last  out  1  qualifies pixel at address VRAM_L-1
busy  out  1  high from accepted start until frame_done
frame_done  out  1  1-cycle pulse, registered, cycle after the last-pixel transfer

Behaviour:
- Reset values: vram_rd_addr=0, pixel_valid=0, pixel_data=0, pixel_first=0, pixel_last=0, busy=0, frame_done=0, state=IDLE, buffer empty, in-flight flag clear.
- States:
  - IDLE: start & !rst (or AUTO_RESTART after DONE) -> STREAM. Read counter=0, busy=1.
  - STREAM: issues reads; after address VRAM_L-1 has issued -> DRAIN.
  - DRAIN: no further reads; waits for the last-pixel transfer -> DONE.
  - DONE: one cycle with frame_done=1, busy=0. Then -> IDLE, or -> STREAM if AUTO_RESTART.
- Read issue: in STREAM, issue when ena & (occupancy + inflight - pop) < 2, where pop = pixel_valid & pixel_ready.
  - On issue, vram_rd_addr = counter, the counter increments by 1, and inflight is set for the next cycle.
  - The address is row-major, y*DISPLAY_WIDTH+x, generated by a plain incrementer with no multiplier.
  - The counter never wraps past VRAM_L-1 within a frame.
- Capture: the cycle after an issue, vram_rd_data is pushed into a 2-entry FIFO, tagged first=(addr==0) and last=(addr==VRAM_L-1).
- The output is the FIFO head. pixel_valid = !empty.
  - Head data/tags are stable while valid & !ready.
  - Push and pop in the same cycle are legal, and occupancy is unchanged.
- Latency: with ready held high, the first pixel is valid 2 clk after start. Steady state is 1 pixel/clk, and a frame takes VRAM_L+3 clk from start to frame_done.
- The credit rule guarantees FIFO overflow is impossible. A bench assertion must flag push when full.
- start while busy is ignored. start coincident with rst: reset wins.
- rst mid-frame: abort immediately. FIFO and inflight are flushed and all outputs return to reset values. frame_done does not pulse.
- ena low mid-frame: issue pauses and the address is held. Already-fetched pixels still drain. Resuming continues from the next address with no gaps or repeats.
- VRAM contents may change during a frame (writer active). The streamer delivers whatever the read port returns; no tearing protection.

Decomposition:
- Shared display package: ILI9341_color_t (existing), plus new constants DISPLAY_WIDTH/DISPLAY_HEIGHT/VRAM_L and the enum streamer_state_t {IDLE, STREAM, DRAIN, DONE}, so the writer FSM and the streamer agree on geometry.
- One sub-module, pixel_fifo2: a 2-entry synchronous FIFO, width VRAM_W+2 (data, first, last), with push/pop/full/empty/count. It is synchronous-reset flushed.
- Top contains the FSM, read counter and credit logic.

Test Plan:
- Use W=4, H=3 (L=12), VRAM preloaded data[i]=16'h0100+i.
  - Stimulus: start, ready=1.
  - Required: 12 transfers, data 0x0100..0x010B in order. first on 0x0100 only, last on 0x010B only. First valid 2 clk after start, frame_done 15 clk after start, busy low after.
- Backpressure:
  - Stimulus: ready pattern 1,0,0,1,0,1,1,0 repeating.
  - Required: same 12-word sequence, no drop or duplicate, head stable while stalled, FIFO never pushes when full.
- ena gating:
  - Stimulus: drop ena for 5 clk after the 4th issue.
  - Required: vram_rd_addr holds at 4, stream resumes at 0x0104 with no gap.
- Reset mid-frame:
  - Stimulus: rst for 1 clk after 6 transfers.
  - Required: next cycle valid=0, busy=0, no frame_done. A new start restarts at 0x0100 with first=1.
- start while busy ignored; AUTO_RESTART=1:
  - Stimulus: run two frames back-to-back.
  - Required: the second frame's first pixel follows frame_done by 2 clk, with a correct first/last per frame.

Source files
------------

// File: rtl/vram_pixel_streamer_pkg.sv
// Shared display geometry and streamer state encoding.
// Keeps the VRAM writer FSM and the read-side streamer in agreement.
package vram_pixel_streamer_pkg;

  typedef logic [15:0] ILI9341_color_t;

  localparam int DISPLAY_WIDTH  = 240;
  localparam int DISPLAY_HEIGHT = 320;
  localparam int VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } streamer_state_t;

endpackage

// File: rtl/vram_pixel_streamer_fifo2.sv
// Two-entry synchronous FIFO holding {last, first, pixel}.
// Head is a register read, so data and tags are stable while stalled.
module pixel_fifo2 #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= !wr_q;
      end
      if (pop_i) begin
        rd_q <= !rd_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/vram_pixel_streamer.sv
// Raster-order VRAM reader producing a framed valid/ready pixel stream.
// Read credits keep occupancy plus in-flight reads within the 2-entry FIFO.
module vram_pixel_streamer #(
  parameter int DISPLAY_WIDTH  = vram_pixel_streamer_pkg::DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = vram_pixel_streamer_pkg::DISPLAY_HEIGHT,
  parameter int VRAM_W =
    $bits(vram_pixel_streamer_pkg::ILI9341_color_t),
  parameter bit AUTO_RESTART   = 1'b0,
  localparam int VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  localparam int AW     = $clog2(VRAM_L)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  output logic [AW-1:0]     vram_rd_addr,
  input  logic [VRAM_W-1:0] vram_rd_data,
  output logic [VRAM_W-1:0] pixel_data,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              pixel_first,
  output logic              pixel_last,
  output logic              busy,
  output logic              frame_done
);

  import vram_pixel_streamer_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(VRAM_L - 1);

  streamer_state_t state_q, state_d;

  logic [AW-1:0]     cnt_q, cnt_d;
  logic              inflight_q;
  logic              tag_first_q;
  logic              tag_last_q;
  logic              busy_q, busy_d;
  logic              done_q;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              room;
  logic              issue;
  logic [VRAM_W+1:0] fifo_din;
  logic [VRAM_W+1:0] fifo_head;

  assign fifo_pop  = pixel_valid & pixel_ready;
  assign fifo_push = inflight_q;
  assign fifo_din  = {tag_last_q, tag_first_q, vram_rd_data};

  // occupancy + inflight - pop < 2, decoded from full/empty
  assign room = fifo_empty
              | (!fifo_full & (!inflight_q | fifo_pop))
              | (fifo_full & !inflight_q & fifo_pop);

  assign issue = (state_q == STREAM) & ena & room;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (issue) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (fifo_pop & fifo_head[VRAM_W+1]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (AUTO_RESTART) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // busy drops through the DONE cycle even when restarting
  assign busy_d = ((state_d == STREAM) | (state_d == DRAIN))
                & (state_q != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
      if (issue) begin
        tag_first_q <= (cnt_q == '0);
        tag_last_q  <= (cnt_q == LAST_ADDR);
      end
      busy_q <= busy_d;
      done_q <= (state_q == DONE);
    end
  end

  pixel_fifo2 #(
    .W (VRAM_W + 2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (fifo_din),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign vram_rd_addr = cnt_q;
  assign pixel_valid  = !fifo_empty;
  assign pixel_data   = fifo_head[VRAM_W-1:0];
  assign pixel_first  = pixel_valid & fifo_head[VRAM_W];
  assign pixel_last   = pixel_valid & fifo_head[VRAM_W+1];
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_vram_pixel_streamer.sv
// Bench for vram_pixel_streamer on a 4x3 frame with a stream scoreboard.
// Instance a is single-shot, instance b runs with AUTO_RESTART.
module tb_vram_pixel_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int L  = W * H;
  localparam int AW = $clog2(L);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          ena_a = 1'b1, start_a = 1'b0, ready_a = 1'b0;
  logic [AW-1:0] addr_a;
  logic [15:0]   rdata_a, data_a;
  logic          valid_a, first_a, last_a, busy_a, done_a;

  logic          ena_b = 1'b1, start_b = 1'b0, ready_b = 1'b1;
  logic [AW-1:0] addr_b;
  logic [15:0]   rdata_b, data_b;
  logic          valid_b, first_b, last_b, busy_b, done_b;

  logic [15:0] vram [L];
  bit          pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  int nvec = 0;
  int errs = 0;
  int idx_a = 0, frames_a = 0;
  int idx_b = 0, frames_b = 0;
  logic        stall_a = 1'b0;
  logic [15:0] hd_a = '0;
  logic [1:0]  ht_a = '0;
  logic [15:0] got_first = '0, got_last = '0;
  time tv_b = 0, td1_b = 0;
  time ts, tn, td;

  always #5 clk = ~clk;

  vram_pixel_streamer #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .VRAM_W        (16),
    .AUTO_RESTART  (1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .ena(ena_a), .start(start_a),
    .vram_rd_addr(addr_a), .vram_rd_data(rdata_a),
    .pixel_data(data_a), .pixel_valid(valid_a),
    .pixel_ready(ready_a), .pixel_first(first_a),
    .pixel_last(last_a), .busy(busy_a), .frame_done(done_a)
  );

  vram_pixel_streamer #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .VRAM_W        (16),
    .AUTO_RESTART  (1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .ena(ena_b), .start(start_b),
    .vram_rd_addr(addr_b), .vram_rd_data(rdata_b),
    .pixel_data(data_b), .pixel_valid(valid_b),
    .pixel_ready(ready_b), .pixel_first(first_b),
    .pixel_last(last_b), .busy(busy_b), .frame_done(done_b)
  );

  always @(posedge clk) begin
    rdata_a <= vram[addr_a];
    rdata_b <= vram[addr_b];
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Scoreboard a: frame is vram[0..L-1] in order, framed by index
  always @(negedge clk) begin
    if (rst) begin
      idx_a   = 0;
      stall_a = 1'b0;
    end else begin
      if (dut_a.fifo_push)
        chk("push_when_full_a", 32'(dut_a.fifo_full), 0);
      if (stall_a) begin
        chk("hold_valid_a", 32'(valid_a), 1);
        chk("hold_data_a", 32'(data_a), 32'(hd_a));
        chk("hold_tags_a", 32'({first_a, last_a}), 32'(ht_a));
      end
      if (valid_a && ready_a) begin
        if (idx_a >= L) begin
          chk("extra_pixel_a", 32'(idx_a), 32'(L - 1));
        end else begin
          chk("pix_data_a", 32'(data_a), 32'(vram[idx_a]));
          chk("pix_first_a", 32'(first_a), 32'(idx_a == 0));
          chk("pix_last_a", 32'(last_a), 32'(idx_a == L - 1));
          if (idx_a == 0) got_first = data_a;
          if (idx_a == L - 1) got_last = data_a;
        end
        idx_a++;
      end
      stall_a = valid_a && !ready_a;
      hd_a    = data_a;
      ht_a    = {first_a, last_a};
      if (done_a) begin
        chk("done_count_a", 32'(idx_a), 32'(L));
        chk("done_busy_a", 32'(busy_a), 0);
        idx_a = 0;
        frames_a++;
      end
    end
  end

  // Scoreboard b: frames repeat back to back
  always @(negedge clk) begin
    if (rst) begin
      idx_b = 0;
    end else begin
      if (dut_b.fifo_push)
        chk("push_when_full_b", 32'(dut_b.fifo_full), 0);
      if (valid_b && ready_b) begin
        chk("pix_data_b", 32'(data_b), 32'(vram[idx_b]));
        chk("pix_first_b", 32'(first_b), 32'(idx_b == 0));
        chk("pix_last_b", 32'(last_b), 32'(idx_b == L - 1));
        if (first_b && frames_b == 1 && tv_b == 0) tv_b = $time;
        idx_b = (idx_b + 1) % L;
      end
      if (done_b) begin
        chk("done_busy_b", 32'(busy_b), 0);
        chk("done_idx_b", 32'(idx_b), 0);
        if (frames_b == 0) td1_b = $time;
        frames_b++;
      end
    end
  end

  task automatic pulse_a(output time t);
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    t = $time;
    #1 start_a = 1'b0;
  endtask

  task automatic wait_frame_a(input int budget, input bit bp);
    int f0;
    f0 = frames_a;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bp) ready_a = pat[i % 8];
      start_a = bp && (i == 6);
      if (frames_a > f0) break;
    end
    start_a = 1'b0;
    chk("frame_done_seen_a", 32'(frames_a), 32'(f0 + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit bad;
    for (int i = 0; i < L; i++) vram[i] = 16'h0100 + 16'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_first", 32'(first_a), 0);
    chk("rst_last", 32'(last_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);

    // Full-rate frame
    ready_a = 1'b1;
    pulse_a(ts);
    tn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_a) begin
        tn = $time;
        break;
      end
    end
    chk("first_valid_latency", 32'((tn - 5 - ts) / 10), 2);
    td = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) begin
        td = $time;
        break;
      end
    end
    chk("frame_done_latency", 32'((td - 5 - ts) / 10), 15);
    @(negedge clk);
    chk("busy_after_done", 32'(busy_a), 0);
    chk("done_pulse_width", 32'(done_a), 0);
    chk("frames_after_t1", 32'(frames_a), 1);
    chk("first_word", 32'(got_first), 32'h0100);
    chk("last_word", 32'(got_last), 32'h010B);

    // Backpressure, with a start pulse while busy
    pulse_a(ts);
    wait_frame_a(300, 1'b1);

    // ena gating after the 4th issue
    ready_a = 1'b1;
    pulse_a(ts);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (addr_a == 4'd4) break;
    end
    ena_a = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("ena_hold_addr", 32'(addr_a), 4);
      if (j == 4) chk("ena_drained", 32'(valid_a), 0);
    end
    @(posedge clk);
    #1 ena_a = 1'b1;
    wait_frame_a(60, 1'b0);

    // Reset mid-frame, with start coincident with reset
    pulse_a(ts);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (idx_a >= 6) break;
    end
    rst = 1'b1;
    ready_a = 1'b0;
    start_a = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start_a = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(valid_a), 0);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_done", 32'(done_a), 0);
    chk("abort_addr", 32'(addr_a), 0);
    chk("abort_data", 32'(data_a), 0);
    chk("abort_tags", 32'({first_a, last_a}), 0);
    ready_a = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_a || busy_a || valid_a) bad = 1'b1;
    end
    chk("quiet_after_abort", 32'(bad), 0);
    got_first = '0;
    pulse_a(ts);
    wait_frame_a(60, 1'b0);
    chk("restart_first_word", 32'(got_first), 32'h0100);

    // AUTO_RESTART back-to-back frames
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    ts = $time;
    #1 start_b = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (frames_b >= 2) break;
    end
    chk("auto_two_frames", 32'(frames_b >= 2), 1);
    chk("auto_done_latency", 32'((td1_b - 5 - ts) / 10), 15);
    chk("auto_restart_gap", 32'((tv_b - td1_b) / 10), 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
